// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Synchronised RX line, mid-bit sampling, valid/ready byte output with error pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  localparam logic [15:0] HALF_TERM = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_TERM = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            term;
  logic                   tick;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;
  logic                   shift_en;
  logic                   load;
  logic                   ovr;
  logic                   ferr;
  logic                   data_entry;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign term = (state_q == S_START) ? HALF_TERM : FULL_TERM;
  assign tick = (cnt_q == term);

`ifdef UART_RX_PARITY_EN
  logic perr;
  logic parity_err_q;
`endif

  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    load     = 1'b0;
    ovr      = 1'b0;
    ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (tick) state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          perr    = (^shift_q) ^ rx_s;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (rx_s) begin
            // An acceptance in the same cycle frees the holding register, so the load wins.
            load    = !valid_q || ready_i;
            ovr     = valid_q && !ready_i;
            state_d = S_IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) || tick || (state_q == S_IDLE) || (state_q == S_WAIT_HIGH)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign data_entry = (state_d == S_DATA) && (state_q != S_DATA);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (data_entry) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (shift_en) shift_q <= {rx_s, shift_q[7:1]};
      if (load) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      frame_err_q <= ferr;
      overrun_q   <= ovr;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst_i) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= perr;
    end
  end
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scenario tasks compared against a byte-level line model.
// Define UART_RX_PARITY_EN for both files to exercise the 8E1 build.
module tb_uart_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned SYNC = 2;
  // start detect after SYNC flops + 1, half start bit, 8 data bits, then stop mid-sample
  localparam int unsigned LAT  = (19 * CPB) / 2 + SYNC + 1;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       uart_rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .uart_rx_i   (uart_rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .parity_err_o(parity_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // Observation side: accepted bytes, pulse counts, valid timing
  logic [7:0]  rxq[$];
  int unsigned fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int unsigned rise_cyc = 0, run = 0, last_run = 0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (valid_o && ready_i) rxq.push_back(data_o);
      if (frame_err_o) fe_cnt++;
      if (overrun_o) ov_cnt++;
      if (parity_err_o) pe_cnt++;
      if (valid_o && !prev_valid) rise_cyc = cyc;
      if (valid_o) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
    end
    prev_valid = valid_o;
  end

  task automatic drive_bit(input logic v, input int unsigned n);
    uart_rx_i = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_body(input logic [7:0] b, input bit par_bad);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_bad, CPB);
`endif
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_body(b, 1'b0);
    drive_bit(1'b1, CPB);
  endtask

  task automatic expect_byte(input string name, input logic [7:0] exp);
    logic [7:0] got;
    total++;
    if (rxq.size() == 0) begin
      bad++;
      $display("FAIL %s: no byte received, required 0x%02h", name, exp);
    end else begin
      got = rxq.pop_front();
      if (got !== exp) begin
        bad++;
        $display("FAIL %s: got 0x%02h, required 0x%02h", name, got, exp);
      end
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; uart_rx_i = 1'b1; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({data_o, valid_o, frame_err_o, overrun_o, parity_err_o, busy_o} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs: got data=%02h v=%b fe=%b ov=%b pe=%b busy=%b, required all 0",
               data_o, valid_o, frame_err_o, overrun_o, parity_err_o, busy_o);
    end
    rst_i = 1'b0;
    drive_bit(1'b1, 4);
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b, required 0", busy_o);
    end
  endtask

  task automatic test_latency;
    int unsigned t0, fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    t0 = cyc;
    send_frame(8'hA5);
    drive_bit(1'b1, 4);
    expect_byte("latency_data", 8'hA5);
    total++;
    if ((rise_cyc - t0 < LAT - 1) || (rise_cyc - t0 > LAT + 1)) begin
      bad++;
      $display("FAIL latency: got %0d clks, required %0d +/-1", rise_cyc - t0, LAT);
    end
    total++;
    if (last_run !== 1) begin
      bad++;
      $display("FAIL valid_width: got %0d clks, required 1", last_run);
    end
    total++;
    if ((fe_cnt != fe0) || (ov_cnt != ov0)) begin
      bad++;
      $display("FAIL latency_flags: fe=%0d ov=%0d new pulses, required 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_glitch;
    int unsigned fe0, n0;
    fe0 = fe_cnt; n0 = rxq.size();
    drive_bit(1'b0, 4);
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL glitch_start_seen: busy=%b, required 1", busy_o);
    end
    uart_rx_i = 1'b1;
    drive_bit(1'b1, CPB);
    total++;
    if ({busy_o, valid_o} !== 2'b00 || fe_cnt != fe0 || rxq.size() != n0) begin
      bad++;
      $display("FAIL glitch_reject: busy=%b valid=%b fe=%0d bytes=%0d, required 0 0 0 0",
               busy_o, valid_o, fe_cnt - fe0, rxq.size() - n0);
    end
  endtask

  task automatic test_frame_error;
    int unsigned fe0, n0;
    fe0 = fe_cnt; n0 = rxq.size();
    send_body(8'h3C, 1'b0);
    drive_bit(1'b0, 3 * CPB);
    total++;
    if ({busy_o, valid_o} !== 2'b10 || rxq.size() != n0) begin
      bad++;
      $display("FAIL break_hold: busy=%b valid=%b bytes=%0d, required 1 0 0", busy_o, valid_o, rxq.size() - n0);
    end
    total++;
    if (fe_cnt - fe0 != 1) begin
      bad++;
      $display("FAIL frame_err_pulse: got %0d pulses, required 1", fe_cnt - fe0);
    end
    drive_bit(1'b1, CPB);
    send_frame(8'h5A);
    drive_bit(1'b1, 4);
    expect_byte("after_frame_err", 8'h5A);
    total++;
    if (rxq.size() != n0) begin
      bad++;
      $display("FAIL frame_err_extra: got %0d extra bytes, required 0", rxq.size() - n0);
    end
  endtask

  task automatic test_overrun;
    int unsigned ov0, n0;
    ov0 = ov_cnt; n0 = rxq.size();
    ready_i = 1'b0;
    send_frame(8'h11);
    send_frame(8'h22);
    drive_bit(1'b1, 4);
    total++;
    if (ov_cnt - ov0 != 1) begin
      bad++;
      $display("FAIL overrun_pulse: got %0d pulses, required 1", ov_cnt - ov0);
    end
    total++;
    if ({valid_o, data_o} !== {1'b1, 8'h11}) begin
      bad++;
      $display("FAIL overrun_hold: valid=%b data=0x%02h, required 1 0x11", valid_o, data_o);
    end
    ready_i = 1'b1;
    drive_bit(1'b1, 2);
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL accept_clear: valid=%b, required 0", valid_o);
    end
    expect_byte("overrun_kept", 8'h11);
    total++;
    if (rxq.size() != n0) begin
      bad++;
      $display("FAIL overrun_discard: got %0d extra bytes, required 0", rxq.size() - n0);
    end
  endtask

  task automatic test_reset_midframe;
    int unsigned fe0, ov0, n0;
    fe0 = fe_cnt; ov0 = ov_cnt; n0 = rxq.size();
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, CPB);
    drive_bit(1'b1, CPB / 2);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    total++;
    if ({data_o, valid_o, frame_err_o, overrun_o, parity_err_o, busy_o} !== 13'h0) begin
      bad++;
      $display("FAIL midframe_reset: got data=%02h v=%b fe=%b ov=%b pe=%b busy=%b, required all 0",
               data_o, valid_o, frame_err_o, overrun_o, parity_err_o, busy_o);
    end
    drive_bit(1'b1, 5 * CPB);
    total++;
    if (fe_cnt != fe0 || ov_cnt != ov0 || rxq.size() != n0) begin
      bad++;
      $display("FAIL midframe_drop: fe=%0d ov=%0d bytes=%0d, required 0 0 0",
               fe_cnt - fe0, ov_cnt - ov0, rxq.size() - n0);
    end
    send_frame(8'h81);
    drive_bit(1'b1, 4);
    expect_byte("after_reset", 8'h81);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp[$];
    logic [7:0] b;
    int unsigned ov0;
    ov0 = ov_cnt;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      exp.push_back(b);
      send_frame(b);
      if (i % 2 == 1) drive_bit(1'b1, $urandom_range(0, 2 * CPB));
    end
    drive_bit(1'b1, 4);
    for (int i = 0; i < 10; i++) expect_byte("random_stream", exp[i]);
    total++;
    if (ov_cnt != ov0) begin
      bad++;
      $display("FAIL stream_overrun: got %0d pulses, required 0", ov_cnt - ov0);
    end
  endtask

  task automatic test_parity;
`ifdef UART_RX_PARITY_EN
    int unsigned pe0;
    pe0 = pe_cnt;
    send_body(8'h07, 1'b1);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, 4);
    total++;
    if (pe_cnt - pe0 != 1) begin
      bad++;
      $display("FAIL parity_bad: got %0d pulses, required 1", pe_cnt - pe0);
    end
    expect_byte("parity_bad_data", 8'h07);
    pe0 = pe_cnt;
    send_frame(8'h07);
    drive_bit(1'b1, 4);
    total++;
    if (pe_cnt != pe0) begin
      bad++;
      $display("FAIL parity_good: got %0d pulses, required 0", pe_cnt - pe0);
    end
    expect_byte("parity_good_data", 8'h07);
`else
    total++;
    if (pe_cnt != 0) begin
      bad++;
      $display("FAIL parity_disabled: got %0d pulses, required 0", pe_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; counterpart of the existing 8N1 transmitter. Deserializes the asynchronous RXD line (9600 baud, 8 data bits LSB first, 1 stop bit, no parity) into bytes. Presents each byte to upper-layer logic with a valid/ready handshake. Sits between the board RX pin and the command/config logic of the ADC-IIR-DAC datapath.

Parameters:
CLKS_PER_BIT, 10417, clk cycles per bit period (100 MHz / 9600); benches use 16; legal range 8..65535
SYNC_STAGES, 2, synchronizer flops on uart_rx_i; legal range 2..3

Ports:
clk  input  1  100 MHz system clock
rst_i  input  1  synchronous reset, active high
uart_rx_i  input  1  serial input from the RX pin, asynchronous, idle high
data_o  output  8  received byte, stable while valid_o is high
valid_o  output  1  byte available; held until accepted
ready_i  input  1  consumer accepts data_o when valid_o && ready_i
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: byte completed while valid_o still high
parity_err_o  output  1  one-cycle pulse: parity mismatch (see Optional Feature)
busy_o  output  1  high whenever FSM is not IDLE

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst_i).
- Reset values: data_o=0x00, valid_o=0, frame_err_o=0, overrun_o=0, parity_err_o=0, busy_o=0, FSM=IDLE, synchronizer flops=1, bit counter=0, shift register=0.
- uart_rx_i passes through SYNC_STAGES flops -> rx_s. All logic uses rx_s only.
- Baud counter: 16-bit, cleared on every state entry. "Tick" = counter reaches terminal value, then counter wraps to 0.
- IDLE: rx_s==0 -> START.
- START: terminal value CLKS_PER_BIT/2-1 (integer division); at tick, rx_s==0 -> DATA; rx_s==1 -> IDLE (glitch rejected, no flags).
- DATA: terminal value CLKS_PER_BIT-1, so sampling lands mid-bit. At each tick, shift register shifts right with rx_s inserted at bit 7 (LSB first); bit counter increments. After the 8th sample -> STOP (or PARITY when the macro is set). Bit counter range 0..7; it is reset to 0 on DATA entry.
- STOP: terminal value CLKS_PER_BIT-1. At tick:
  rx_s==1 and valid_o==0 -> data_o<=shift register, valid_o<=1 on the next edge, then IDLE.
  rx_s==1 and valid_o==1 -> overrun_o pulses 1 cycle; the new byte is discarded and data_o keeps the old byte; then IDLE.
  rx_s==0 -> frame_err_o pulses 1 cycle; data_o/valid_o unchanged; then WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then IDLE. Prevents a break condition from being taken as a new start bit.
- Handshake: valid_o clears on the edge after valid_o && ready_i. If acceptance and a new byte load fall on the same cycle, the load wins: valid_o stays 1, data_o updates, and no overrun is flagged.
- Latency: valid_o rises at stop-bit mid-sample + 1 clk. This is about 9.5 bit periods plus SYNC_STAGES clocks after the start-bit falling edge.
- The next start bit is recognized from the first cycle back in IDLE. Back-to-back frames need no gap.
- Reset mid-frame: returns to IDLE within one cycle; the partial byte is dropped and no flag pulses.
- busy_o = (state != IDLE). Combinational from the state register.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1. After DATA the FSM enters PARITY (terminal value CLKS_PER_BIT-1) and samples the parity bit. If XOR(data bits, parity bit) != 0, parity_err_o pulses 1 cycle at that sample; the byte is still delivered normally after STOP. Total frame is 11 bits.
- Not defined: PARITY state is absent and parity_err_o is tied to 0.

Test Plan:
CLKS_PER_BIT=16, 8N1 frame 0xA5, ready_i=1 -> data_o=0xA5 and a 1-cycle valid_o at the expected latency (±1 clk); no error flags.
Low glitch of 4 clks on idle line -> FSM returns to IDLE at half-bit sample; valid_o, frame_err_o and busy_o are low afterwards.
Frame 0x3C with stop bit held low for 3 bit periods -> frame_err_o pulses once; valid_o stays 0; no reception until the line goes high; a following 0x5A frame is received correctly.
ready_i=0, back-to-back frames 0x11 then 0x22 -> data_o=0x11 and valid_o held; overrun_o pulses at the 0x22 stop sample; after ready_i=1, valid_o clears.
rst_i asserted for 1 clk during bit 4 of frame 0xFF -> all outputs at reset values; the next frame 0x81 is received correctly.
With UART_RX_PARITY_EN, 0x07 sent with parity 0 (wrong) -> parity_err_o pulses once and data_o=0x07 with valid_o; with parity 1 -> no parity_err_o.
